// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
// Requester ids, the in-flight read tag, default latency/fairness limits.
package riscv_mem_pkg;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  localparam int RD_LATENCY_DEF   = 2;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W         = 4;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  localparam tag_t TAG_NONE = '{
    valid: 1'b0,
    owner: REQ_IF
  };

  function automatic tag_t read_tag(
    input logic owner
  );
    return '{valid: 1'b1, owner: owner};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the RAM.
// slave: arbiter view. master: datapath + RAM view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_W/8-1:0]   dm_be;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  ram_en;
  logic [DATA_W/8-1:0]   ram_we;
  logic [ADDR_W-3:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  logic                  stall_f;
  logic                  stall_m;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_gnt,
    output if_rvalid,
    output if_rdata,
    input  dm_req,
    input  dm_we,
    input  dm_be,
    input  dm_addr,
    input  dm_wdata,
    output dm_gnt,
    output dm_rvalid,
    output dm_rdata,
    output ram_en,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata,
    output stall_f,
    output stall_m
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_gnt,
    input  if_rvalid,
    input  if_rdata,
    output dm_req,
    output dm_we,
    output dm_be,
    output dm_addr,
    output dm_wdata,
    input  dm_gnt,
    input  dm_rvalid,
    input  dm_rdata,
    input  ram_en,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata,
    input  stall_f,
    input  stall_m
  );

endinterface

// File: rtl/mem_port_arbiter_tag_pipe.sv
// mem_tag_pipe: DEPTH-stage shift register of read tags.
// Ports: clk, reset (async, high), tag_in, tag_out (DEPTH cycles later).
module mem_tag_pipe
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = RD_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= TAG_NONE;
      end
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch and data-memory stages.
// Ports: clk, reset (async, high), bus (slave: requests, RAM, stalls).
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = RD_LATENCY_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [STARVE_W-1:0] LIMIT =
    STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_nxt;
  logic                starve_full;

  logic dm_win;
  logic if_win;

  logic              ram_en;
  logic [BE_W-1:0]   ram_we;
  logic [ADDR_W-3:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  tag_t tag_in;
  tag_t tag_out;
  logic if_hit;
  logic dm_hit;

  // Byte offset is dropped: every access is a full word.
  logic unused_offset;
  assign unused_offset =
    ^{bus.if_addr[1:0], bus.dm_addr[1:0]};

  assign starve_full = (starve_cnt == LIMIT);

  // Data side has priority until fetch has
  // waited LIMIT data grants in a row.
  always_comb begin
    dm_win = 1'b0;
    if_win = 1'b0;
    if (!reset) begin
      dm_win = bus.dm_req &&
               !(bus.if_req && starve_full);
      if_win = bus.if_req && !dm_win;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!bus.if_req || if_win) begin
      starve_nxt = '0;
    end else if (dm_win && !starve_full) begin
      starve_nxt = starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  // RAM command for the winner; stores need no tag.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    tag_in    = TAG_NONE;
    unique case (1'b1)
      dm_win: begin
        ram_en   = 1'b1;
        ram_addr = bus.dm_addr[ADDR_W-1:2];
        if (bus.dm_we) begin
          ram_we    = bus.dm_be;
          ram_wdata = bus.dm_wdata;
        end else begin
          tag_in = read_tag(REQ_DM);
        end
      end
      if_win: begin
        ram_en   = 1'b1;
        ram_addr = bus.if_addr[ADDR_W-1:2];
        tag_in   = read_tag(REQ_IF);
      end
      default: ;
    endcase
  end

  mem_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tags (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign if_hit = tag_out.valid &&
                  (tag_out.owner == REQ_IF);
  assign dm_hit = tag_out.valid &&
                  (tag_out.owner == REQ_DM);

  assign bus.if_gnt    = if_win;
  assign bus.dm_gnt    = dm_win;
  assign bus.if_rvalid = if_hit;
  assign bus.dm_rvalid = dm_hit;
  assign bus.if_rdata  = if_hit ? bus.ram_rdata : '0;
  assign bus.dm_rdata  = dm_hit ? bus.ram_rdata : '0;

  assign bus.ram_en    = ram_en;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;

  assign bus.stall_f = !reset && bus.if_req && !if_win;
  assign bus.stall_m = !reset && bus.dm_req && !dm_win;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle RAM model.
// Read expectations are queued at issue and checked by a monitor.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  logic init_mem;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t if_q[$];
  exp_t dm_q[$];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .RD_LATENCY   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pattern(input int w);
    return 32'hC0DE_0000 | 32'(w);
  endfunction

  logic [31:0] mem [256];
  logic [31:0] rd_s1;
  logic [31:0] rd_s2;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
    end else if (bus.ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_we[b])
          mem[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
      rd_s1 <= mem[bus.ram_addr[7:0]];
    end
    rd_s2 <= rd_s1;
  end

  assign bus.ram_rdata = rd_s2;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int p);
    logic        v;
    logic [31:0] d;
    exp_t        e;
    bit          have;
    string       nv;
    string       nd;
    v    = p != 0 ? bus.dm_rvalid : bus.if_rvalid;
    d    = p != 0 ? bus.dm_rdata : bus.if_rdata;
    nv   = p != 0 ? "dm_rvalid" : "if_rvalid";
    nd   = p != 0 ? "dm_rdata" : "if_rdata";
    have = p != 0 ? dm_q.size() > 0 : if_q.size() > 0;
    if (have) e = p != 0 ? dm_q[0] : if_q[0];
    if (reset) begin
      chk1({nv, "_in_reset"}, v, 1'b0);
    end else if (have && e.cyc == cyc) begin
      chk1(nv, v, 1'b1);
      chk(nd, d, e.data);
      if (p != 0) void'(dm_q.pop_front());
      else        void'(if_q.pop_front());
    end else begin
      chk1({nv, "_idle"}, v, 1'b0);
      chk({nd, "_idle_zero"}, d, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic req,
                        input logic [31:0] addr);
    bus.if_req  = req;
    bus.if_addr = addr;
  endtask

  task automatic set_dm(input logic req,
                        input logic we,
                        input logic [3:0] be,
                        input logic [31:0] addr,
                        input logic [31:0] wdata);
    bus.dm_req   = req;
    bus.dm_we    = we;
    bus.dm_be    = be;
    bus.dm_addr  = addr;
    bus.dm_wdata = wdata;
  endtask

  task automatic idle();
    set_if(1'b0, 32'h0);
    set_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int          t;
    int          dk;
    int          fk;
    logic [7:0]  e_dm;
    logic [7:0]  e_if;
    clk      = 1'b0;
    reset    = 1'b1;
    init_mem = 1'b1;
    idle();

    // Requests held during reset must see no grant.
    set_if(1'b1, 32'h4);
    set_dm(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    tick();
    tick();
    init_mem = 1'b0;
    @(negedge clk);
    chk1("rst_if_gnt", bus.if_gnt, 1'b0);
    chk1("rst_dm_gnt", bus.dm_gnt, 1'b0);
    chk1("rst_ram_en", bus.ram_en, 1'b0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
    chk1("rst_stall_f", bus.stall_f, 1'b0);
    chk1("rst_stall_m", bus.stall_m, 1'b0);
    tick();
    idle();
    reset = 1'b0;
    @(negedge clk);
    tick();

    // Two reads in flight, then reset: nothing returns.
    set_dm(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    @(negedge clk);
    chk1("t1_dm_gnt", bus.dm_gnt, 1'b1);
    tick();
    idle();
    set_if(1'b1, 32'h0);
    @(negedge clk);
    chk1("t1_if_gnt", bus.if_gnt, 1'b1);
    tick();
    idle();
    reset = 1'b1;
    if_q.delete();
    dm_q.delete();
    @(negedge clk);
    tick();
    reset = 1'b0;
    repeat (5) tick();

    // Fetch-only back-to-back burst.
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      set_if(1'b1, 32'(4 * k));
      @(negedge clk);
      chk1("t2_if_gnt", bus.if_gnt, 1'b1);
      chk1("t2_ram_en", bus.ram_en, 1'b1);
      chk("t2_ram_we", 32'(bus.ram_we), 32'h0);
      chk("t2_ram_addr", 32'(bus.ram_addr), 32'(k));
      chk1("t2_stall_f", bus.stall_f, 1'b0);
      if_q.push_back('{pattern(k), t + k + 2});
      tick();
    end

    // Collision: data load wins, fetch follows.
    set_if(1'b1, 32'hC);
    set_dm(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    t = cyc;
    @(negedge clk);
    chk1("t3_dm_gnt", bus.dm_gnt, 1'b1);
    chk1("t3_if_gnt", bus.if_gnt, 1'b0);
    chk1("t3_stall_f", bus.stall_f, 1'b1);
    chk1("t3_stall_m", bus.stall_m, 1'b0);
    chk("t3_ram_addr", 32'(bus.ram_addr), 32'h10);
    dm_q.push_back('{32'hC0DE_0010, t + 2});
    tick();
    bus.dm_req = 1'b0;
    @(negedge clk);
    chk1("t3_if_gnt2", bus.if_gnt, 1'b1);
    chk1("t3_stall_f2", bus.stall_f, 1'b0);
    chk("t3_ram_addr2", 32'(bus.ram_addr), 32'h3);
    if_q.push_back('{32'hC0DE_0003, t + 3});
    tick();
    idle();

    // Partial store, then aligned and misaligned loads.
    set_dm(1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    @(negedge clk);
    chk1("t4_dm_gnt", bus.dm_gnt, 1'b1);
    chk1("t4_ram_en", bus.ram_en, 1'b1);
    chk("t4_ram_we", 32'(bus.ram_we), 32'h3);
    chk("t4_ram_addr", 32'(bus.ram_addr), 32'h40);
    chk("t4_ram_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
    tick();
    set_dm(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    t = cyc;
    @(negedge clk);
    chk("t4_ld_ram_we", 32'(bus.ram_we), 32'h0);
    dm_q.push_back('{32'hC0DE_BEEF, t + 2});
    tick();
    set_dm(1'b1, 1'b0, 4'h0, 32'h103, 32'h55);
    @(negedge clk);
    chk("t4_mis_ram_addr", 32'(bus.ram_addr), 32'h40);
    dm_q.push_back('{32'hC0DE_BEEF, t + 3});
    tick();
    idle();
    @(negedge clk);
    chk1("idle_ram_en", bus.ram_en, 1'b0);
    chk("idle_ram_we", 32'(bus.ram_we), 32'h0);
    chk("idle_ram_addr", 32'(bus.ram_addr), 32'h0);
    chk("idle_ram_wdata", bus.ram_wdata, 32'h0);
    tick();

    // Starvation: fetch held against six data loads.
    e_dm = 8'b0110_1111;
    e_if = 8'b1001_0000;
    dk   = 0;
    fk   = 0;
    t    = cyc;
    for (int i = 0; i < 8; i++) begin
      set_if(fk < 2, 32'h20 + 32'(4 * fk));
      set_dm(dk < 6, 1'b0, 4'h0, 32'h80 + 32'(4 * dk), 32'h0);
      @(negedge clk);
      chk1("t5_dm_gnt", bus.dm_gnt, e_dm[i]);
      chk1("t5_if_gnt", bus.if_gnt, e_if[i]);
      chk1("t5_stall_f", bus.stall_f, (fk < 2) && !e_if[i]);
      chk1("t5_stall_m", bus.stall_m, (dk < 6) && !e_dm[i]);
      if (i == 4) chk("t5_starve_full", 32'(dut.starve_cnt), 32'h4);
      if (i == 5) chk("t5_starve_clr", 32'(dut.starve_cnt), 32'h0);
      if (e_dm[i]) begin
        dm_q.push_back('{pattern(32 + dk), t + i + 2});
        dk++;
      end
      if (e_if[i]) begin
        if_q.push_back('{pattern(8 + fk), t + i + 2});
        fk++;
      end
      tick();
    end
    idle();
    repeat (6) tick();

    chk("if_q_drained", 32'(if_q.size()), 32'h0);
    chk("dm_q_drained", 32'(dm_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
